// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a small
// byte FIFO with registered pop data, full/empty flags and one-cycle error pulses.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RxD,
  input  logic       Data_Read,
  output logic [7:0] RX_Data,
  output logic       RX_Full,
  output logic       RX_Empty,
  output logic       Frame_Err,
  output logic       Overrun,
  output logic       Parity_Err
);

  localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int CW        = $clog2(BIT_TICKS);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int PW        = AW + 1;

  localparam logic [CW-1:0] TICK_LAST = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] TICK_HALF = CW'(BIT_TICKS / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } rx_push_t;

  // rx_q is one flop behind rx_s2 and only feeds falling-edge detection
  logic rx_s1, rx_s2, rx_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= RxD;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          stop_hit;
  logic          par_bad;
  rx_push_t      push;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        // Edge detect needs a high-then-low, so after a bad stop bit the
        // receiver naturally waits for the line to go idle before re-arming.
        IDLE: if (rx_q && !rx_s2) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (cnt == TICK_HALF) begin
          cnt <= '0;
          if (!rx_s2) begin
            state <= DATA;
            idx   <= '0;
          end else begin
            state <= IDLE;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
        DATA: if (cnt == TICK_LAST) begin
          cnt   <= '0;
          shreg <= {rx_s2, shreg[7:1]};
          idx   <= idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (cnt == TICK_LAST) begin
          cnt     <= '0;
          par_bit <= rx_s2;
          state   <= STOP;
        end else begin
          cnt <= cnt + CW'(1);
        end
`endif
        STOP: if (cnt == TICK_LAST) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_hit = (state == STOP) && (cnt == TICK_LAST);

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit carry an even number of ones
  assign par_bad = (par_bit != ^shreg);

  always_ff @(posedge Clk) begin
    if (Rst) Parity_Err <= 1'b0;
    else     Parity_Err <= stop_hit && rx_s2 && par_bad;
  end
`else
  assign par_bad    = 1'b0;
  assign Parity_Err = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) Frame_Err <= 1'b0;
    else     Frame_Err <= stop_hit && !rx_s2;
  end

  assign push.vld  = stop_hit && rx_s2 && !par_bad;
  assign push.data = shreg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic          pop, wr_ok;

  // A pop on a full FIFO frees the slot being written in the same cycle
  assign pop    = Data_Read && !RX_Empty;
  assign wr_ok  = push.vld && (!RX_Full || pop);
  assign wr_nxt = wr_ptr + PW'(wr_ok);
  assign rd_nxt = rd_ptr + PW'(pop);

  always_ff @(posedge Clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= push.data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      RX_Data  <= 8'h00;
      RX_Empty <= 1'b1;
      RX_Full  <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      if (pop) RX_Data <= mem[rd_ptr[AW-1:0]];
      RX_Empty <= (wr_nxt == rd_nxt);
      RX_Full  <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      Overrun  <= push.vld && !wr_ok;
    end
  end

endmodule
